// File: rtl/cic_comp_fir.sv
// Time-multiplexed I/Q FIR droop compensator behind the CIC decimator.
// Each accepted sample runs TAPS sequential MAC cycles, then a rounded, saturated strobe.
module cic_comp_fir #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned TAPS       = 21,
  parameter int unsigned COEF_WIDTH = 18,
  parameter int unsigned COEF_FRAC  = 16,
  parameter logic [TAPS*COEF_WIDTH-1:0] COEFS = (TAPS*COEF_WIDTH)'(65536)
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic signed [WIDTH-1:0] i_inph_data,
  input  logic signed [WIDTH-1:0] i_quad_data,
  input  logic                    i_valid,
  output logic                    o_ready,
  output logic signed [WIDTH-1:0] o_inph_data,
  output logic signed [WIDTH-1:0] o_quad_data,
  output logic                    o_valid,
  output logic                    o_overflow
);

  localparam int unsigned KW = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int unsigned PW = WIDTH + COEF_WIDTH;
  localparam int unsigned AW = PW + $clog2(TAPS);
  localparam logic [KW-1:0] LAST = KW'(TAPS - 1);
  localparam logic signed [AW-1:0] RND     = AW'(1) <<< (COEF_FRAC - 1);
  localparam logic signed [AW-1:0] SAT_MAX = (AW'(1) <<< (WIDTH - 1)) - AW'(1);
  localparam logic signed [AW-1:0] SAT_MIN = -(AW'(1) <<< (WIDTH - 1));

  typedef enum logic [1:0] {ST_IDLE, ST_MAC, ST_OUT} state_t;

  state_t state_q, state_d;

  logic [KW-1:0]           k_q, k_d;
  logic [KW-1:0]           rd_q, rd_d;
  logic [KW-1:0]           wr_q, wr_d;
  logic signed [AW-1:0]    acc_inph_q, acc_inph_d;
  logic signed [AW-1:0]    acc_quad_q, acc_quad_d;
  logic signed [WIDTH-1:0] inph_q, inph_d;
  logic signed [WIDTH-1:0] quad_q, quad_d;
  logic                    valid_q, valid_d;
  logic                    ready_q, ready_d;
  logic                    ovf_q, ovf_d;
  logic                    dl_we;

  logic signed [WIDTH-1:0]      dl_inph_q [TAPS];
  logic signed [WIDTH-1:0]      dl_quad_q [TAPS];
  logic signed [COEF_WIDTH-1:0] coef_a    [TAPS];
  logic signed [PW-1:0]         prod_inph, prod_quad;

  for (genvar g = 0; g < TAPS; g++) begin : g_coef
    assign coef_a[g] = COEFS[g*COEF_WIDTH +: COEF_WIDTH];
  end

  // Products are formed at full width so the accumulator can never wrap.
  assign prod_inph = PW'(coef_a[k_q]) * PW'(dl_inph_q[rd_q]);
  assign prod_quad = PW'(coef_a[k_q]) * PW'(dl_quad_q[rd_q]);

  function automatic logic signed [WIDTH-1:0] round_sat(input logic signed [AW-1:0] acc);
    logic signed [AW-1:0] r;
    r = (acc + RND) >>> COEF_FRAC;
    if (r > SAT_MAX) begin
      r = SAT_MAX;
    end else if (r < SAT_MIN) begin
      r = SAT_MIN;
    end
    return r[WIDTH-1:0];
  endfunction

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (i_valid) state_d = ST_MAC;
      ST_MAC:  if (k_q == LAST) state_d = ST_OUT;
      ST_OUT:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    k_d        = k_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    acc_inph_d = acc_inph_q;
    acc_quad_d = acc_quad_q;
    inph_d     = inph_q;
    quad_d     = quad_q;
    valid_d    = 1'b0;
    ready_d    = (state_d == ST_IDLE);
    ovf_d      = ovf_q | (i_valid & (state_q != ST_IDLE));
    dl_we      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (i_valid) begin
          dl_we      = 1'b1;
          acc_inph_d = '0;
          acc_quad_d = '0;
          k_d        = '0;
          rd_d       = wr_q;
        end
      end
      ST_MAC: begin
        acc_inph_d = acc_inph_q + AW'(prod_inph);
        acc_quad_d = acc_quad_q + AW'(prod_quad);
        k_d        = (k_q == LAST) ? '0 : k_q + KW'(1);
        rd_d       = (rd_q == '0) ? LAST : rd_q - KW'(1);
        if (k_q == LAST) begin
          wr_d = (wr_q == LAST) ? '0 : wr_q + KW'(1);
        end
      end
      ST_OUT: begin
        inph_d  = round_sat(acc_inph_q);
        quad_d  = round_sat(acc_quad_q);
        valid_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      k_q        <= '0;
      rd_q       <= '0;
      wr_q       <= '0;
      acc_inph_q <= '0;
      acc_quad_q <= '0;
      inph_q     <= '0;
      quad_q     <= '0;
      valid_q    <= 1'b0;
      ready_q    <= 1'b1;
      ovf_q      <= 1'b0;
      for (int unsigned t = 0; t < TAPS; t++) begin
        dl_inph_q[t] <= '0;
        dl_quad_q[t] <= '0;
      end
    end else begin
      k_q        <= k_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      acc_inph_q <= acc_inph_d;
      acc_quad_q <= acc_quad_d;
      inph_q     <= inph_d;
      quad_q     <= quad_d;
      valid_q    <= valid_d;
      ready_q    <= ready_d;
      ovf_q      <= ovf_d;
      if (dl_we) begin
        dl_inph_q[wr_q] <= i_inph_data;
        dl_quad_q[wr_q] <= i_quad_data;
      end
    end
  end

  assign o_ready     = ready_q;
  assign o_inph_data = inph_q;
  assign o_quad_data = quad_q;
  assign o_valid     = valid_q;
  assign o_overflow  = ovf_q;

endmodule

// File: tb/tb_cic_comp_fir.sv
// Directed bench for cic_comp_fir: four parameterisations (identity, impulse,
// saturation, rounding) driven from a vector table plus overflow and reset sequences.
module tb_cic_comp_fir;

  logic clk;
  logic rst [4];
  logic vld [4];
  logic rdy [4];
  logic ov  [4];
  logic ovf [4];
  logic signed [15:0] di [4];
  logic signed [15:0] dq [4];
  logic signed [15:0] oi [4];
  logic signed [15:0] oq [4];

  int tests = 0;
  int fails = 0;

  typedef struct {
    int n;
    bit pre_rst;
    int vi;
    int vq;
    int ei;
    int eq;
  } vec_t;

  vec_t vecs [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  cic_comp_fir u_ident (
    .i_clock(clk), .i_reset(rst[0]), .i_inph_data(di[0]), .i_quad_data(dq[0]),
    .i_valid(vld[0]), .o_ready(rdy[0]), .o_inph_data(oi[0]), .o_quad_data(oq[0]),
    .o_valid(ov[0]), .o_overflow(ovf[0]));

  cic_comp_fir #(.TAPS(4),
                 .COEFS({18'sd8192, -18'sd16384, 18'sd32768, 18'sd16384})) u_imp (
    .i_clock(clk), .i_reset(rst[1]), .i_inph_data(di[1]), .i_quad_data(dq[1]),
    .i_valid(vld[1]), .o_ready(rdy[1]), .o_inph_data(oi[1]), .o_quad_data(oq[1]),
    .o_valid(ov[1]), .o_overflow(ovf[1]));

  cic_comp_fir #(.TAPS(4), .COEFS({4{18'sd65536}})) u_sat (
    .i_clock(clk), .i_reset(rst[2]), .i_inph_data(di[2]), .i_quad_data(dq[2]),
    .i_valid(vld[2]), .o_ready(rdy[2]), .o_inph_data(oi[2]), .o_quad_data(oq[2]),
    .o_valid(ov[2]), .o_overflow(ovf[2]));

  cic_comp_fir #(.TAPS(4), .COEFS(72'(32768))) u_rnd (
    .i_clock(clk), .i_reset(rst[3]), .i_inph_data(di[3]), .i_quad_data(dq[3]),
    .i_valid(vld[3]), .o_ready(rdy[3]), .o_inph_data(oi[3]), .o_quad_data(oq[3]),
    .o_valid(ov[3]), .o_overflow(ovf[3]));

  function automatic int taps_of(input int n);
    return (n == 0) ? 21 : 4;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic pulse_reset(input int n);
    @(negedge clk);
    rst[n] = 1'b1;
    repeat (2) @(negedge clk);
    rst[n] = 1'b0;
  endtask

  // One sample in, wait (bounded) for its strobe, check latency, data, strobe width and hold.
  task automatic run_vec(input int n, input int vi, input int vq, input int ei, input int eq,
                         input string tag);
    int lat;
    @(negedge clk);
    chk({tag, " ready"}, int'(rdy[n]), 1);
    di[n] = 16'(vi);
    dq[n] = 16'(vq);
    vld[n] = 1'b1;
    @(negedge clk);
    vld[n] = 1'b0;
    chk({tag, " busy"}, int'(rdy[n]), 0);
    lat = 1;
    while (!ov[n] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, " latency"}, lat, taps_of(n) + 2);
    chk({tag, " I"}, int'(oi[n]), ei);
    chk({tag, " Q"}, int'(oq[n]), eq);
    chk({tag, " ready at strobe"}, int'(rdy[n]), 1);
    @(negedge clk);
    chk({tag, " strobe width"}, int'(ov[n]), 0);
    chk({tag, " I held"}, int'(oi[n]), ei);
  endtask

  // Accept a sample, then present a second one three cycles later while busy.
  task automatic ovf_seq(input int n, input int vi, input int vq, input int ei, input int eq,
                         input string tag);
    int nval;
    int lat;
    @(negedge clk);
    di[n] = 16'(vi);
    dq[n] = 16'(vq);
    vld[n] = 1'b1;
    @(negedge clk);
    vld[n] = 1'b0;
    repeat (2) @(negedge clk);
    di[n] = 16'sd1234;
    dq[n] = -16'sd1234;
    vld[n] = 1'b1;
    @(negedge clk);
    vld[n] = 1'b0;
    chk({tag, " overflow set"}, int'(ovf[n]), 1);
    nval = 0;
    lat = 4;
    repeat (40) begin
      if (ov[n]) begin
        nval++;
        if (nval == 1) begin
          chk({tag, " latency"}, lat, taps_of(n) + 2);
          chk({tag, " I"}, int'(oi[n]), ei);
          chk({tag, " Q"}, int'(oq[n]), eq);
        end
      end
      @(negedge clk);
      lat++;
    end
    chk({tag, " strobe count"}, nval, 1);
    chk({tag, " overflow sticky"}, int'(ovf[n]), 1);
  endtask

  // Accept a sample, assert reset five cycles later, expect no strobe and cleared state.
  task automatic reset_seq(input int n, input int vi, input int vq, input string tag);
    int seen;
    seen = 0;
    @(negedge clk);
    di[n] = 16'(vi);
    dq[n] = 16'(vq);
    vld[n] = 1'b1;
    @(negedge clk);
    vld[n] = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (ov[n]) seen++;
    end
    rst[n] = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (ov[n]) seen++;
    end
    rst[n] = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (ov[n]) seen++;
    end
    chk({tag, " no strobe"}, seen, 0);
    chk({tag, " I zero"}, int'(oi[n]), 0);
    chk({tag, " Q zero"}, int'(oq[n]), 0);
    chk({tag, " overflow cleared"}, int'(ovf[n]), 0);
    chk({tag, " ready"}, int'(rdy[n]), 1);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      rst[i] = 1'b1;
      vld[i] = 1'b0;
      di[i] = '0;
      dq[i] = '0;
    end

    // identity
    vecs.push_back('{0, 1'b0, 1000, -2000, 1000, -2000});
    vecs.push_back('{0, 1'b0, -32768, 32767, -32768, 32767});
    // impulse response through taps 16384, 32768, -16384, 8192
    vecs.push_back('{1, 1'b0, 4000, -4000, 1000, -1000});
    vecs.push_back('{1, 1'b0, 0, 0, 2000, -2000});
    vecs.push_back('{1, 1'b0, 0, 0, -1000, 1000});
    vecs.push_back('{1, 1'b0, 0, 0, 500, -500});
    vecs.push_back('{1, 1'b0, 0, 0, 0, 0});
    // saturation, all taps unity
    for (int i = 0; i < 4; i++) vecs.push_back('{2, 1'b0, 32767, 32767, 32767, 32767});
    for (int i = 0; i < 4; i++) vecs.push_back('{2, (i == 0), -32768, -32768, -32768, -32768});
    // rounding half toward +inf with a 0.5 tap
    vecs.push_back('{3, 1'b0, 3, -3, 2, -1});
    vecs.push_back('{3, 1'b0, -3, 3, -1, 2});
    vecs.push_back('{3, 1'b0, 1, -1, 1, 0});
    vecs.push_back('{3, 1'b0, -1, 1, 0, 1});

    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) rst[i] = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("reset%0d ready", i), int'(rdy[i]), 1);
      chk($sformatf("reset%0d valid", i), int'(ov[i]), 0);
      chk($sformatf("reset%0d overflow", i), int'(ovf[i]), 0);
      chk($sformatf("reset%0d I", i), int'(oi[i]), 0);
      chk($sformatf("reset%0d Q", i), int'(oq[i]), 0);
    end

    foreach (vecs[i]) begin
      if (vecs[i].pre_rst) pulse_reset(vecs[i].n);
      run_vec(vecs[i].n, vecs[i].vi, vecs[i].vq, vecs[i].ei, vecs[i].eq,
              $sformatf("vec%0d", i));
    end

    ovf_seq(0, 111, -222, 111, -222, "ovf21");
    repeat (5) @(negedge clk);
    run_vec(0, 300, -300, 300, -300, "ovf21 next");
    chk("ovf21 still sticky", int'(ovf[0]), 1);

    // dropped 1234 must not enter history: following zeros give the pure impulse tail
    ovf_seq(1, 4000, -4000, 1000, -1000, "ovf4");
    run_vec(1, 0, 0, 2000, -2000, "ovf4 hist1");
    run_vec(1, 0, 0, -1000, 1000, "ovf4 hist2");

    reset_seq(0, 5000, -5000, "rst mac");
    reset_seq(1, 8000, 8000, "rst out");
    run_vec(1, 4000, -4000, 1000, -1000, "post rst imp");
    run_vec(1, 0, 0, 2000, -2000, "post rst tail");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
